// File: rtl/vend_pkg.sv
// Shared types for the vending session controller: FSM state encoding,
// coin codes and the coin-code to credit-step conversion.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    COLLECT  = 2'b01,
    DISPENSE = 2'b10,
    CHANGE   = 2'b11
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_25   = 2'b01;
  localparam logic [1:0] COIN_50   = 2'b10;
  localparam logic [1:0] COIN_RSVD = 2'b11;

  // Credit steps for a coin code; NONE and the reserved code carry no value.
  function automatic logic [1:0] coin_value(input logic [1:0] code);
    logic [1:0] val;
    val = 2'd0;
    case (code)
      COIN_25: val = 2'd1;
      COIN_50: val = 2'd2;
      default: val = 2'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_session_ctrl_if.sv
// Customer/dispenser/hopper side of the vending session controller.
// master drives coins, cancel and acks; slave is the controller.
interface vend_session_ctrl_if #(
  parameter int CREDIT_W = 3
);
  logic [1:0]          coin;
  logic                cancel;
  logic                disp_ack;
  logic                chg_ack;
  logic                disp_req;
  logic                chg_req;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin, cancel, disp_ack, chg_ack,
    input  disp_req, chg_req, coin_reject, credit, busy
  );

  modport slave (
    input  coin, cancel, disp_ack, chg_ack,
    output disp_req, chg_req, coin_reject, credit, busy
  );
endinterface

// File: rtl/vend_idle_timer.sv
// Counts consecutive qualifying cycles and flags when TIMEOUT is reached.
// Saturates at TIMEOUT; clear has priority over counting.
module vend_idle_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/vend_session_ctrl.sv
// Vending session FSM: collects coins, one dispense handshake, coin-by-coin change.
// Moore requests; coin_reject is a registered pulse. Optional idle refund: VEND_SESSION_TIMEOUT_EN.
module vend_session_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE      = 3,
  parameter int MAX_CREDIT = 7,
  parameter int CREDIT_W   = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  vend_session_ctrl_if.slave   bus
);
  localparam int SUM_W = CREDIT_W + 1;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                reject_q, reject_d;

  logic [1:0]          coin_val;
  logic                coin_ok;
  logic                coin_any;
  logic [SUM_W-1:0]    credit_sum;
  logic                timeout_hit;
  logic                abort;

  assign coin_val   = coin_value(bus.coin);
  assign coin_ok    = (coin_val != 2'd0);
  assign coin_any   = (bus.coin != COIN_NONE);
  assign credit_sum = SUM_W'(credit_q) + SUM_W'(coin_val);
  assign abort      = bus.cancel || timeout_hit;

`ifdef VEND_SESSION_TIMEOUT_EN
  // Any coin attempt, accepted or not, restarts the idle window.
  vend_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk      (clk),
    .reset    (reset),
    .count_en ((state_q == COLLECT) && !coin_any),
    .clear    ((state_q != COLLECT) || coin_any),
    .expired  (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    reject_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (coin_ok) begin
          credit_d = CREDIT_W'(coin_val);
          state_d  = COLLECT;
        end else begin
          reject_d = coin_any;
        end
      end

      COLLECT: begin
        // A cancel (or idle expiry) wins over a coin arriving in the same cycle.
        if (coin_ok && !abort && (credit_sum <= SUM_W'(MAX_CREDIT))) begin
          credit_d = credit_sum[CREDIT_W-1:0];
        end else begin
          reject_d = coin_any;
        end

        if (abort) begin
          state_d = CHANGE;
        end else if (credit_q >= CREDIT_W'(PRICE)) begin
          state_d = DISPENSE;
        end
      end

      DISPENSE: begin
        reject_d = coin_any;
        if (bus.disp_ack) begin
          credit_d = credit_q - CREDIT_W'(PRICE);
          state_d  = (credit_q > CREDIT_W'(PRICE)) ? CHANGE : IDLE;
        end
      end

      CHANGE: begin
        reject_d = coin_any;
        if (credit_q == '0) begin
          state_d = IDLE;
        end else if (bus.chg_ack) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  assign bus.disp_req    = (state_q == DISPENSE);
  assign bus.chg_req     = (state_q == CHANGE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.credit      = credit_q;
  assign bus.coin_reject = reject_q;

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Drives two controllers (PRICE 3 and 7) with directed then random stimulus
// and compares every cycle against a session-level reference model.
module tb_vend_session_ctrl;

  localparam int MAXC    = 7;
  localparam int TIMEOUT = 15;
`ifdef VEND_SESSION_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum int {M_IDLE, M_COLLECT, M_VEND, M_REFUND} mphase_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       cancel = 1'b0;
  logic       disp_ack = 1'b0;
  logic       chg_ack = 1'b0;

  int errors = 0;
  int checks = 0;

  int      price [2] = '{3, 7};
  mphase_t m_ph  [2];
  int      m_cr  [2];
  int      m_rej [2];
  int      m_to  [2];

  always #5 clk = ~clk;

  vend_session_ctrl_if #(.CREDIT_W(3)) bus0 ();
  vend_session_ctrl_if #(.CREDIT_W(3)) bus1 ();

  assign bus0.coin = coin;  assign bus0.cancel = cancel;
  assign bus0.disp_ack = disp_ack;  assign bus0.chg_ack = chg_ack;
  assign bus1.coin = coin;  assign bus1.cancel = cancel;
  assign bus1.disp_ack = disp_ack;  assign bus1.chg_ack = chg_ack;

  vend_session_ctrl #(.PRICE(3), .MAX_CREDIT(MAXC), .CREDIT_W(3), .TIMEOUT(TIMEOUT)) u_dut_p3 (
    .clk(clk), .reset(reset), .bus(bus0));
  vend_session_ctrl #(.PRICE(7), .MAX_CREDIT(MAXC), .CREDIT_W(3), .TIMEOUT(TIMEOUT)) u_dut_p7 (
    .clk(clk), .reset(reset), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = M_IDLE; m_cr[k] = 0; m_rej[k] = 0; m_to[k] = 0;
    end
  endtask

  // One clock edge of the session rules for controller k.
  task automatic model_step(input int k, input logic [1:0] c, input logic cn,
                            input logic da, input logic ca);
    int val;
    bit abort;
    val = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
    m_rej[k] = 0;
    case (m_ph[k])
      M_IDLE: begin
        if (val > 0) begin
          m_cr[k] = val; m_ph[k] = M_COLLECT; m_to[k] = 0;
        end else if (c != 2'b00) m_rej[k] = 1;
      end
      M_COLLECT: begin
        int old_cr;
        old_cr = m_cr[k];
        abort = cn || (TO_EN && m_to[k] == TIMEOUT);
        if (c != 2'b00) begin
          if (val > 0 && !abort && old_cr + val <= MAXC) m_cr[k] = old_cr + val;
          else m_rej[k] = 1;
        end
        m_to[k] = (c != 2'b00) ? 0 : m_to[k] + 1;
        if (abort) m_ph[k] = M_REFUND;
        else if (old_cr >= price[k]) m_ph[k] = M_VEND;
      end
      M_VEND: begin
        if (c != 2'b00) m_rej[k] = 1;
        if (da) begin
          m_cr[k] = m_cr[k] - price[k];
          m_ph[k] = (m_cr[k] > 0) ? M_REFUND : M_IDLE;
        end
      end
      M_REFUND: begin
        if (c != 2'b00) m_rej[k] = 1;
        if (ca) m_cr[k] = m_cr[k] - 1;
        if (m_cr[k] == 0) m_ph[k] = M_IDLE;
      end
      default: m_ph[k] = M_IDLE;
    endcase
  endtask

  task automatic check_unit(input int k);
    logic dr, cr, bz, rj;
    logic [2:0] cd;
    if (k == 0) begin
      dr = bus0.disp_req; cr = bus0.chg_req; bz = bus0.busy; rj = bus0.coin_reject; cd = bus0.credit;
    end else begin
      dr = bus1.disp_req; cr = bus1.chg_req; bz = bus1.busy; rj = bus1.coin_reject; cd = bus1.credit;
    end
    check($sformatf("p%0d disp_req", price[k]), 32'(dr), 32'(m_ph[k] == M_VEND));
    check($sformatf("p%0d chg_req", price[k]), 32'(cr), 32'(m_ph[k] == M_REFUND));
    check($sformatf("p%0d busy", price[k]), 32'(bz), 32'(m_ph[k] != M_IDLE));
    check($sformatf("p%0d credit", price[k]), 32'(cd), 32'(m_cr[k]));
    check($sformatf("p%0d coin_reject", price[k]), 32'(rj), 32'(m_rej[k]));
  endtask

  // Called just after a falling edge: apply inputs, clock once, check.
  task automatic cycle(input logic [1:0] c, input logic cn = 1'b0,
                       input logic da = 1'b0, input logic ca = 1'b0);
    coin = c; cancel = cn; disp_ack = da; chg_ack = ca;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, c, cn, da, ca);
    @(negedge clk);
    coin = 2'b00; cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
    check_unit(0);
    check_unit(1);
  endtask

  // Reset asserted between edges must clear outputs without waiting for clk.
  task automatic reset_pulse();
    reset = 1'b0;
    #1;
    check("async disp_req", 32'(bus0.disp_req), 32'd0);
    check("async chg_req", 32'(bus1.chg_req | bus0.chg_req), 32'd0);
    check("async busy", 32'(bus0.busy | bus1.busy), 32'd0);
    check("async credit", 32'(bus0.credit | bus1.credit), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_unit(0);
    check_unit(1);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("reset busy", 32'(bus0.busy), 32'd0);
    check("reset credit", 32'(bus0.credit), 32'd0);
    check("reset coin_reject", 32'(bus0.coin_reject), 32'd0);
    check_unit(0);
    check_unit(1);
    reset = 1'b1;

    // Exact price: 25 then 50.
    cycle(2'b01);
    check("exact credit1", 32'(bus0.credit), 32'd1);
    cycle(2'b10);
    check("exact credit3", 32'(bus0.credit), 32'd3);
    cycle(2'b00);
    check("exact disp_req", 32'(bus0.disp_req), 32'd1);
    cycle(2'b00, 1'b0, 1'b1);
    check("exact idle", 32'(bus0.busy), 32'd0);
    check("exact no change", 32'(bus0.chg_req), 32'd0);

    // Overpay, with a coin offered while dispensing.
    cycle(2'b10);
    cycle(2'b10);
    cycle(2'b00);
    cycle(2'b01);
    check("vend coin_reject", 32'(bus0.coin_reject), 32'd1);
    check("vend credit held", 32'(bus0.credit), 32'd4);
    cycle(2'b00, 1'b0, 1'b1);
    check("overpay chg_req", 32'(bus0.chg_req), 32'd1);
    check("overpay credit", 32'(bus0.credit), 32'd1);
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
    check("overpay idle", 32'(bus0.busy), 32'd0);

    // Cancel with refund, then cancel racing a coin.
    cycle(2'b10);
    cycle(2'b00, 1'b1);
    check("cancel chg_req", 32'(bus0.chg_req), 32'd1);
    check("cancel credit", 32'(bus0.credit), 32'd2);
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
    check("cancel idle", 32'(bus0.busy), 32'd0);
    reset_pulse();
    cycle(2'b01);
    cycle(2'b10, 1'b1);
    check("race coin_reject", 32'(bus0.coin_reject), 32'd1);
    check("race credit", 32'(bus0.credit), 32'd1);
    cycle(2'b00, 1'b0, 1'b0, 1'b1);

    // Reserved code is always refused.
    cycle(2'b11);
    check("rsvd coin_reject", 32'(bus0.coin_reject), 32'd1);
    check("rsvd credit", 32'(bus0.credit), 32'd0);

    // Overflow guard on the PRICE=7 unit: 2+2+2 = 6, then a 50 does not fit.
    reset_pulse();
    cycle(2'b10); cycle(2'b10); cycle(2'b10);
    cycle(2'b10);
    check("ovf coin_reject", 32'(bus1.coin_reject), 32'd1);
    check("ovf credit", 32'(bus1.credit), 32'd6);
    reset_pulse();

    // Reset while a dispense is pending.
    cycle(2'b10); cycle(2'b10); cycle(2'b00);
    check("pre-reset disp_req", 32'(bus0.disp_req), 32'd1);
    reset_pulse();

`ifdef VEND_SESSION_TIMEOUT_EN
    cycle(2'b01);
    repeat (TIMEOUT + 1) cycle(2'b00);
    check("timeout chg_req", 32'(bus0.chg_req), 32'd1);
    cycle(2'b00, 1'b0, 1'b0, 1'b1);
`endif

    for (int i = 0; i < 4000; i++) begin
      int r;
      logic [1:0] c;
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
      end else begin
        r = $urandom_range(0, 99);
        c = (r < 50) ? 2'b00 : (r < 72) ? 2'b01 : (r < 94) ? 2'b10 : 2'b11;
        cycle(c, ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 35),
              ($urandom_range(0, 99) < 45));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
